// File: rtl/multicycle_alu_pkg.sv
// Shared opcode/function constants, opcode enum and FSM state enum for multicycle_alu.
package multicycle_alu_pkg;

   typedef enum logic [2:0] {
      OP_LW    = 3'b000,
      OP_SW    = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_CEQ   = 3'b100,
      OP_CLT   = 3'b101,
      OP_SEI   = 3'b110,
      OP_OTHER = 3'b111
   } op_e;

   localparam logic [2:0] FN_SHIFTL_X = 3'b000;
   localparam logic [2:0] FN_SHIFTL_F = 3'b001;
   localparam logic [2:0] FN_SHIFTL_O = 3'b010;
   localparam logic [2:0] FN_SHIFTR_X = 3'b011;
   localparam logic [2:0] FN_SHIFTR_F = 3'b100;
   localparam logic [2:0] FN_SHIFTR_O = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

   function automatic logic fn_is_shift(input logic [2:0] fn);
      return fn <= FN_SHIFTR_O;
   endfunction

   function automatic logic fn_is_left(input logic [2:0] fn);
      return fn <= FN_SHIFTL_O;
   endfunction

   // Fill bit for a shift request; f is the F register value at acceptance.
   function automatic logic fn_fill(input logic [2:0] fn, input logic f);
      logic fill;
      case (fn)
         FN_SHIFTL_F, FN_SHIFTR_F: fill = f;
         FN_SHIFTL_O, FN_SHIFTR_O: fill = 1'b1;
         default:                  fill = 1'b0;
      endcase
      return fill;
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shifter: shifts din by one position left or right, inserting fill.
module alu_shift_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] din,
   input  logic             dir_left,
   input  logic             fill,
   output logic [WIDTH-1:0] dout,
   output logic             bit_out
);

   always_comb begin
      if (dir_left) begin
         dout    = {din[WIDTH-2:0], fill};
         bit_out = din[WIDTH-1];
      end else begin
         dout    = {fill, din[WIDTH-1:1]};
         bit_out = din[0];
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU with valid/ready handshakes; shifts run one bit per cycle.
// Optional signed-overflow output ovf when MULTICYCLE_ALU_OVF_EN is defined.
module multicycle_alu
   import multicycle_alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [2:0]         fn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               flag,
   output logic               err
`ifdef MULTICYCLE_ALU_OVF_EN
   ,
   output logic               ovf
`endif
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               f_q, f_d;
   logic               err_q, err_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_left_q, dir_left_d;
   logic               fill_q, fill_d;

   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   step_out;
   logic               step_bit;

   assign sum_ext = {1'b0, a} + {1'b0, b};
   assign diff    = a - b;

   alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .din      (result_q),
      .dir_left (dir_left_q),
      .fill     (fill_q),
      .dout     (step_out),
      .bit_out  (step_bit)
   );

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      f_d        = f_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      dir_left_d = dir_left_q;
      fill_d     = fill_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_DONE;
               err_d   = 1'b0;
               case (op_e'(op))
                  OP_ADD: begin
                     result_d = sum_ext[WIDTH-1:0];
                     f_d      = sum_ext[WIDTH];
                  end
                  OP_SUB: begin
                     result_d = diff;
                     f_d      = (a < b);
                  end
                  OP_CEQ: begin
                     f_d      = (a == b);
                     result_d = {{(WIDTH-1){1'b0}}, (a == b)};
                  end
                  OP_CLT: begin
                     f_d      = (a < b);
                     result_d = {{(WIDTH-1){1'b0}}, (a < b)};
                  end
                  OP_SEI: result_d = b;
                  OP_OTHER: begin
                     if (fn_is_shift(fn)) begin
                        result_d   = a;
                        dir_left_d = fn_is_left(fn);
                        fill_d     = fn_fill(fn, f_q);
                        if (shamt != '0) begin
                           cnt_d   = shamt;
                           state_d = S_SHIFT;
                        end
                     end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                     end
                  end
                  default: begin
                     result_d = '0;
                     err_d    = 1'b1;
                  end
               endcase
            end
         end
         S_SHIFT: begin
            result_d = step_out;
            f_d      = step_bit;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         result_q   <= '0;
         f_q        <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         dir_left_q <= 1'b0;
         fill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         f_q        <= f_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         dir_left_q <= dir_left_d;
         fill_q     <= fill_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flag      = f_q;
   assign err       = err_q & out_valid;

`ifdef MULTICYCLE_ALU_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == S_IDLE && in_valid) begin
         case (op_e'(op))
            OP_ADD:  ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: ovf_d = 1'b0;
         endcase
      end else if (state_q == S_DONE && out_ready) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q & out_valid;
`endif

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, datapath width in bits (minimum 4).
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  opcode: LW=000, SW=001, ADD=010, SUB=011, CEQ=100, CLT=101, SEI=110, OTHER=111.
REQ-008 fn  input  3  shift function, used only when op=OTHER: SHIFTL_X=000, SHIFTL_F=001, SHIFTL_O=010, SHIFTR_X=011, SHIFTR_F=100, SHIFTR_O=101.
REQ-009 a, b  input  WIDTH  operands; shamt  input  SHAMT_W  shift distance.
REQ-010 out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH; flag  output  1  current F register; err  output  1  illegal request.

Function
REQ-012 Request SHALL be accepted only when in_valid and in_ready are both 1 in the same cycle; op, fn, a, b, shamt and F SHALL be captured at acceptance.
REQ-013 FSM SHALL have states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 ADD/SUB/CEQ/CLT/SEI and illegal requests SHALL go IDLE->DONE; out_valid rises the cycle after acceptance.
REQ-015 ADD: result=a+b mod 2^WIDTH, F=carry-out; SUB: result=a-b mod 2^WIDTH, F=1 on borrow (a<b unsigned).
REQ-016 CEQ: F=(a==b); CLT: F=(a<b unsigned); both result={WIDTH-1 zeros, new F}.
REQ-017 SEI: result=b, F unchanged.
REQ-018 Shifts SHALL move one bit per cycle in SHIFT for exactly shamt cycles; fill bit is 0 (_X), captured F (_F) or 1 (_O); out_valid rises shamt+1 cycles after acceptance.
REQ-019 shamt=0 SHALL go IDLE->DONE with result=a and F unchanged.
REQ-020 After a shift with shamt>0, F SHALL equal the last bit shifted out.
REQ-021 shamt>=WIDTH SHALL run full shamt cycles (result all fill bits).
REQ-022 LW, SW, or OTHER with fn=110/111 SHALL yield err=1, result=0, F unchanged; err SHALL be 0 otherwise, valid only while out_valid=1.
REQ-023 In DONE, result/err SHALL hold stable until out_valid&&out_ready, then return to IDLE; a new request is not accepted in that same cycle.
REQ-024 in_valid while not in IDLE SHALL be ignored (no queueing).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=1 after deassertion, out_valid=0, result=0, err=0, F=0, shift counter=0, including mid-SHIFT or mid-DONE.

Configuration
REQ-026 With macro MULTICYCLE_ALU_OVF_EN defined, the block SHALL add output ovf (1 bit), set in DONE for ADD/SUB on signed two's-complement overflow, else 0; reset 0.
REQ-027 Without MULTICYCLE_ALU_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Opcode and function constants, op enum (LW..OTHER) and FSM state enum SHALL live in shared package definitions.
REQ-029 A sub-module alu_shift_step (one-bit shift with direction and fill inputs, combinational) SHALL be instantiated by the SHIFT datapath.

Verification (WIDTH=8)
REQ-030 ADD a=8'hF0 b=8'h20 -> result 8'h10, flag=1, out_valid 1 cycle after accept.
REQ-031 SHIFTL_O a=8'h81 shamt=3 -> result 8'h0F, flag=0, out_valid 4 cycles after accept.
REQ-032 CLT a=3 b=5 (result 8'h01, flag=1), then SHIFTR_F a=8'h00 shamt=2 -> result 8'hC0, flag=0.
REQ-033 out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; in_valid pulses ignored.
REQ-034 rst_n low during SHIFT (SHIFTL_X shamt=6, cycle 3) -> out_valid=0, flag=0, in_ready=1 after release; op=LW -> err=1, result=0.
REQ-035 With MULTICYCLE_ALU_OVF_EN: ADD 8'h7F+8'h01 -> result 8'h80, ovf=1, flag=0.
